// File: rtl/adc_pkg.sv
// Shared definitions for the ADC scan sequencer: mux channel codes, scan FSM states
// and the channel-stepping helper.
package adc_pkg;

  localparam logic [3:0] MUX_A0        = 4'd1;
  localparam logic [3:0] MUX_A1        = 4'd2;
  localparam logic [3:0] MUX_A2        = 4'd3;
  localparam logic [3:0] MUX_A3        = 4'd4;
  localparam logic [3:0] MUX_A4        = 4'd5;
  localparam logic [3:0] MUX_A5        = 4'd6;
  localparam logic [3:0] MUX_AREF      = 4'd7;
  localparam logic [3:0] MUX_3V3       = 4'd8;
  localparam logic [3:0] MUX_VBAT_HALF = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    NEXT
  } scan_state_t;

  // Next set bit of mask strictly above cur, wrapping; returns cur if it is the only one.
  function automatic logic [3:0] next_ch(input logic [15:0] mask, input logic [3:0] cur);
    logic [3:0] idx;
    logic [3:0] r;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = cur + 4'(i);
      if (!found && mask[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_avg.sv
// Accumulates 2^AVG_LOG2 conversion results and presents the truncated mean
// combinationally alongside done on the cycle of the last sample.
module adc_avg #(
  parameter int RES_W    = 15,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RES_W-1:0] sample,
  input  logic             sample_vld,
  output logic             done,
  output logic [RES_W-1:0] avg
);

  localparam int ACC_W = RES_W + AVG_LOG2;
  localparam int CW    = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CW-1:0]    cnt;

  assign sum  = acc + ACC_W'(sample);
  assign done = sample_vld && (cnt == LAST);
  assign avg  = sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_vld) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan.sv
// Scans the analog mux over CH_MASK, settles, gates the sense stage and stores the
// per-channel average in a register file behind a 1-cycle registered read port.
module adc_scan
  import adc_pkg::*;
#(
  parameter int          RES_W          = 15,
  parameter logic [15:0] CH_MASK        = 16'h003E,
  parameter int          SETTLE_CYCLES  = 480,
  parameter int          AVG_LOG2       = 2,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [3:0]       adc_mux,
  output logic             adc_mux_en_n,
  output logic             sense_go,
  input  logic [RES_W-1:0] sense_res,
  input  logic             sense_rdy,
  input  logic [3:0]       rd_ch,
  output logic [RES_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             scan_done,
  output logic             timeout_err
);

  if (CH_MASK == 16'h0000) begin : g_bad_mask
    $error("adc_scan: CH_MASK must select at least one channel");
  end
  if (AVG_LOG2 > 8) begin : g_bad_avg
    $error("adc_scan: AVG_LOG2 must not exceed 8");
  end

  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       FIRST_CH = next_ch(CH_MASK, 4'hF);

  scan_state_t      state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [3:0]       mux_nxt, nxt_ch;
  logic             avg_start, tmo_hit, smp_vld, avg_done;
  logic [RES_W-1:0] avg_val;
  logic [RES_W-1:0] result [16];
  logic [15:0]      valid;

  // Settle and timeout phases never overlap, so they share one down-counter.
  assign smp_vld   = sense_go && sense_rdy && enable;
  assign nxt_ch    = next_ch(CH_MASK, adc_mux);
  assign scan_done = (state == NEXT) && (nxt_ch <= adc_mux);

  adc_avg #(.RES_W(RES_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (avg_start),
    .sample     (sense_res),
    .sample_vld (smp_vld),
    .done       (avg_done),
    .avg        (avg_val)
  );

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    mux_nxt   = adc_mux;
    avg_start = 1'b0;
    tmo_hit   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          tmr_nxt   = SET_LOAD;
        end
        SETTLE: begin
          if (tmr == '0) begin
            state_nxt = CONVERT;
            avg_start = 1'b1;
            tmr_nxt   = TMO_LOAD;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        CONVERT: begin
          if (smp_vld) begin
            tmr_nxt = TMO_LOAD;
            if (avg_done) state_nxt = NEXT;
          end else if (tmr == '0) begin
            tmo_hit   = 1'b1;
            state_nxt = NEXT;
          end else begin
            tmr_nxt = tmr - TMR_W'(1);
          end
        end
        NEXT: begin
          mux_nxt   = nxt_ch;
          state_nxt = SETTLE;
          tmr_nxt   = SET_LOAD;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      adc_mux      <= FIRST_CH;
      adc_mux_en_n <= 1'b1;
      sense_go     <= 1'b0;
      timeout_err  <= 1'b0;
      valid        <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      adc_mux      <= mux_nxt;
      adc_mux_en_n <= (state_nxt == IDLE);
      sense_go     <= (state_nxt == CONVERT);
      timeout_err  <= timeout_err | tmo_hit;
      if (avg_done) valid[adc_mux] <= 1'b1;
      rd_data      <= result[rd_ch];
      rd_valid     <= valid[rd_ch];
    end
  end

  // Results survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (avg_done) result[adc_mux] <= avg_val;
  end

endmodule
